// File: rtl/jamma_pkg.sv
// Shared types and idle constants for the JAMMA joystick scanner.
package jamma_pkg;

    typedef enum logic [1:0] {
        A_SETTLE,
        A_SAMPLE,
        B_SETTLE,
        B_SAMPLE
    } scan_state_e;

    localparam logic [7:0] JOY_IDLE  = 8'hFF;
    localparam logic [1:0] COIN_IDLE = 2'b11;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: a word must be sampled DEBOUNCE times in a row
// before it is allowed through to the output register.
module debounce_chan #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic             pclk,
    input  logic             pll_lckd,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] out,
    output logic             stable
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sample_en) begin
            if (raw != cand_q) begin
                cand_d = raw;
                cnt_d  = CW'(1);
            end else if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Reloading while saturated is harmless: candidate is frozen then.
        out_d = (cnt_q == CNT_MAX) ? cand_q : out_q;
    end

    always_ff @(posedge pclk or negedge pll_lckd) begin
        if (!pll_lckd) begin
            cand_q <= '1;
            cnt_q  <= '0;
            out_q  <= '1;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign out    = out_q;
    assign stable = (cnt_q == CNT_MAX);

endmodule

// File: rtl/jamma_joy_scan.sv
// Time-multiplexed JAMMA input scanner: drives JSELECT, samples the shared
// JJOY bus per player slot and debounces player A/B words and coin lines.
module jamma_joy_scan
    import jamma_pkg::*;
#(
    parameter int SETTLE   = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic       pclk,
    input  logic       pll_lckd,
    input  logic [7:0] jjoy,
    input  logic [1:0] jcoin,
    input  logic [5:0] joy_local,
    output logic       jselect,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic [1:0] coin,
    output logic       valid,
    output logic       changed
);

    localparam int SW = $clog2(SETTLE);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);

    // {jjoy, jcoin, joy_local} through a 2-flop synchroniser
    logic [15:0] sync1_q, sync2_q;

    always_ff @(posedge pclk or negedge pll_lckd) begin
        if (!pll_lckd) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {jjoy, jcoin, joy_local};
            sync2_q <= sync1_q;
        end
    end

    logic [7:0] s_jjoy;
    logic [1:0] s_jcoin;
    logic [5:0] s_local;
    assign {s_jjoy, s_jcoin, s_local} = sync2_q;

    scan_state_e   state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          jsel_q, jsel_d;

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            A_SETTLE: if (scnt_q == '0) state_d = A_SAMPLE;
                      else              scnt_d  = scnt_q - 1'b1;
            A_SAMPLE: begin
                state_d = B_SETTLE;
                scnt_d  = SETTLE_LD;
            end
            B_SETTLE: if (scnt_q == '0) state_d = B_SAMPLE;
                      else              scnt_d  = scnt_q - 1'b1;
            B_SAMPLE: begin
                state_d = A_SETTLE;
                scnt_d  = SETTLE_LD;
            end
            default: begin
                state_d = A_SETTLE;
                scnt_d  = SETTLE_LD;
            end
        endcase
        // Registered from next state so the mux moves on the same edge as the FSM.
        jsel_d = (state_d == B_SETTLE) || (state_d == B_SAMPLE);
    end

    always_ff @(posedge pclk or negedge pll_lckd) begin
        if (!pll_lckd) begin
            state_q <= A_SETTLE;
            scnt_q  <= SETTLE_LD;
            jsel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            jsel_q  <= jsel_d;
        end
    end

    logic samp_a, samp_b, stable_a, stable_b, stable_c;
    logic [7:0] raw_a;
    assign samp_a = (state_q == A_SAMPLE);
    assign samp_b = (state_q == B_SAMPLE);
    assign raw_a  = s_jjoy & {2'b11, s_local};

    debounce_chan #(.WIDTH(8), .DEBOUNCE(DEBOUNCE)) u_chan_a (
        .pclk(pclk), .pll_lckd(pll_lckd), .sample_en(samp_a),
        .raw(raw_a), .out(joystick1), .stable(stable_a)
    );

    debounce_chan #(.WIDTH(8), .DEBOUNCE(DEBOUNCE)) u_chan_b (
        .pclk(pclk), .pll_lckd(pll_lckd), .sample_en(samp_b),
        .raw(s_jjoy), .out(joystick2), .stable(stable_b)
    );

    debounce_chan #(.WIDTH(2), .DEBOUNCE(DEBOUNCE)) u_chan_coin (
        .pclk(pclk), .pll_lckd(pll_lckd), .sample_en(samp_a | samp_b),
        .raw(s_jcoin), .out(coin), .stable(stable_c)
    );

    logic [17:0] outs, prev_q;
    logic        valid_q, valid_d, chg_q, chg_d;
    assign outs = {joystick1, joystick2, coin};

    always_comb begin
        valid_d = valid_q | (stable_a & stable_b);
        chg_d   = (outs != prev_q);
    end

    always_ff @(posedge pclk or negedge pll_lckd) begin
        if (!pll_lckd) begin
            prev_q  <= {JOY_IDLE, JOY_IDLE, COIN_IDLE};
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            prev_q  <= outs;
            valid_q <= valid_d;
            chg_q   <= chg_d;
        end
    end

    // Coin channel stability does not gate valid; only players do.
    logic unused_stable_c;
    assign unused_stable_c = stable_c;

    assign jselect = jsel_q;
    assign valid   = valid_q;
    assign changed = chg_q;

endmodule

// File: tb/tb_jamma_joy_scan.sv
// Directed bench for jamma_joy_scan with default SETTLE=4, DEBOUNCE=4.
module tb_jamma_joy_scan;

    logic       pclk = 1'b0;
    logic       pll_lckd = 1'b0;
    logic [7:0] pa = 8'hFF, pb = 8'hFF;
    logic [1:0] jcoin = 2'b11;
    logic [5:0] joy_local = 6'h3F;
    logic [7:0] jjoy;
    logic       jselect, valid, changed;
    logic [7:0] joystick1, joystick2;
    logic [1:0] coin;

    // external mux: player A on jselect=0, player B on jselect=1
    assign jjoy = jselect ? pb : pa;

    jamma_joy_scan dut (
        .pclk(pclk), .pll_lckd(pll_lckd), .jjoy(jjoy), .jcoin(jcoin),
        .joy_local(joy_local), .jselect(jselect), .joystick1(joystick1),
        .joystick2(joystick2), .coin(coin), .valid(valid), .changed(changed)
    );

    always #5 pclk = ~pclk;

    int n_chk = 0, n_fail = 0, cyc = 0, n_chg = 0, c0 = 0;

    always @(negedge pclk) if (changed === 1'b1) n_chg++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        cyc++;
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("rst_j1", 32'(joystick1), 32'hFF);
        check("rst_j2", 32'(joystick2), 32'hFF);
        check("rst_coin", 32'(coin), 32'h3);
        check("rst_jsel", 32'(jselect), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_chg", 32'(changed), 0);

        // idle scan: jselect low cycles 0..4, high 5..9
        pll_lckd = 1'b1;
        cyc = 0;
        check("jsel_c0", 32'(jselect), 0);
        to_cycle(4);  check("jsel_c4", 32'(jselect), 0);
        to_cycle(5);  check("jsel_c5", 32'(jselect), 1);
        to_cycle(9);  check("jsel_c9", 32'(jselect), 1);
        to_cycle(10); check("jsel_c10", 32'(jselect), 0);
        to_cycle(40); check("valid_c40", 32'(valid), 0);
        to_cycle(41); check("valid_c41", 32'(valid), 1);
        check("idle_nochg", 32'(n_chg), 0);

        // player A press; A samples at 54,64,74,84
        to_cycle(45); pa = 8'hFE; c0 = n_chg;
        to_cycle(85); check("a_j1_pre", 32'(joystick1), 32'hFF);
        to_cycle(86); check("a_j1", 32'(joystick1), 32'hFE);
        check("a_j2", 32'(joystick2), 32'hFF);
        check("a_chg86", 32'(changed), 0);
        to_cycle(87); check("a_chg87", 32'(changed), 1);
        to_cycle(88); check("a_chg88", 32'(changed), 0);
        to_cycle(90); check("a_npulse", 32'(n_chg - c0), 1);

        // player B glitch for 3 samples (99,109,119), then back
        pb = 8'hF7; c0 = n_chg;
        to_cycle(120); pb = 8'hFF;
        to_cycle(135); check("bg_j2", 32'(joystick2), 32'hFF);
        check("bg_nochg", 32'(n_chg - c0), 0);
        // hold for samples 139..169
        pb = 8'hF7;
        to_cycle(170); check("b_j2_pre", 32'(joystick2), 32'hFF);
        to_cycle(171); check("b_j2", 32'(joystick2), 32'hF7);
        to_cycle(180); check("b_npulse", 32'(n_chg - c0), 1);

        // local DB9 merge into player 1; samples 184..214
        pa = 8'hFF; joy_local = 6'b111101;
        to_cycle(215); check("loc_j1_pre", 32'(joystick1), 32'hFE);
        to_cycle(216); check("loc_j1", 32'(joystick1), 32'hFD);
        check("loc_j2", 32'(joystick2), 32'hF7);

        // coin: samples at 224,229,234,239
        to_cycle(220); jcoin = 2'b10; c0 = n_chg;
        to_cycle(240); check("coin_pre", 32'(coin), 32'h3);
        to_cycle(241); check("coin_set", 32'(coin), 32'h2);
        to_cycle(245); check("coin_npulse", 32'(n_chg - c0), 1);
        jcoin = 2'b11;
        to_cycle(265); check("coin_rel_pre", 32'(coin), 32'h2);
        to_cycle(266); check("coin_rel", 32'(coin), 32'h3);

        // restore joystick1 = FE, then reset during B_SETTLE
        to_cycle(270); pa = 8'hFE; joy_local = 6'h3F;
        to_cycle(305); check("r_j1_pre", 32'(joystick1), 32'hFD);
        to_cycle(306); check("r_j1", 32'(joystick1), 32'hFE);
        check("r_jsel_b", 32'(jselect), 1);
        pll_lckd = 1'b0;
        #1;
        check("ar_j1", 32'(joystick1), 32'hFF);
        check("ar_j2", 32'(joystick2), 32'hFF);
        check("ar_coin", 32'(coin), 32'h3);
        check("ar_jsel", 32'(jselect), 0);
        check("ar_valid", 32'(valid), 0);
        repeat (2) @(posedge pclk);
        #1;
        pll_lckd = 1'b1;
        cyc = 0;
        to_cycle(4);  check("rr_jsel_c4", 32'(jselect), 0);
        to_cycle(5);  check("rr_jsel_c5", 32'(jselect), 1);
        to_cycle(35); check("rr_j1_pre", 32'(joystick1), 32'hFF);
        to_cycle(36); check("rr_j1", 32'(joystick1), 32'hFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
